// File: rtl/shift_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// arm7_shift_pkg
// Definitions shared between shift_operand_stage and barrel_shifter:
//   - shift-type encoding (LSL/LSR/ASR/ROR = 0..3)
//   - operand-stage state encoding
//   - bit positions of the data-processing instruction fields
//   - operand_t: the full operand/override bundle handed to the shifter
// ---------------------------------------------------------------------------
package arm7_shift_pkg;

  localparam int DATA_W = 32;

  // Data-processing instruction field positions
  localparam int INSTR_I_BIT  = 25;
  localparam int ROT_HI       = 11;
  localparam int ROT_LO       = 8;
  localparam int IMM8_HI      = 7;
  localparam int IMM8_LO      = 0;
  localparam int SHAMT_HI     = 11;
  localparam int SHAMT_LO     = 7;
  localparam int TYPE_HI      = 6;
  localparam int TYPE_LO      = 5;
  localparam int REGSHIFT_BIT = 4;
  localparam int RS_HI        = 11;
  localparam int RS_LO        = 8;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RS_RD = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        typ;
    logic [4:0]        amt;
    logic              cin;
    logic              ovr_en;
    logic [DATA_W-1:0] ovr_data;
    logic              ovr_cout;
  } operand_t;

endpackage

// File: rtl/shift_operand_stage_if.sv
// ---------------------------------------------------------------------------
// shift_operand_stage_if
// Bundles the instruction handshake, the Rs register-file read port and the
// operand handshake toward barrel_shifter.
//   slave  : the operand stage (drives in_ready, rs_req/rs_addr, op_*, ovr_*)
//   master : the surrounding pipeline (drives instr, rm_data, cpsr_c,
//            rs_data, in_valid, out_ready)
// ---------------------------------------------------------------------------
interface shift_operand_stage_if;
  import arm7_shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rm_data;
  logic              cpsr_c;
  logic              rs_req;
  logic [3:0]        rs_addr;
  logic [DATA_W-1:0] rs_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] op_data;
  logic [1:0]        op_type;
  logic [4:0]        op_amt;
  logic              op_cin;
  logic              ovr_en;
  logic [DATA_W-1:0] ovr_data;
  logic              ovr_cout;

  modport slave (
    input  in_valid, instr, rm_data, cpsr_c, rs_data, out_ready,
    output in_ready, rs_req, rs_addr, out_valid,
           op_data, op_type, op_amt, op_cin, ovr_en, ovr_data, ovr_cout
  );

  modport master (
    output in_valid, instr, rm_data, cpsr_c, rs_data, out_ready,
    input  in_ready, rs_req, rs_addr, out_valid,
           op_data, op_type, op_amt, op_cin, ovr_en, ovr_data, ovr_cout
  );
endinterface

// File: rtl/shift_operand_stage_resolve.sv
// ---------------------------------------------------------------------------
// shift_amt_resolve (combinational)
// Turns a register-specified shift (type, Rs[7:0], Rm) into either a shifter
// command with a 0..31 amount or a direct override of result and carry for
// amounts the 5-bit shifter cannot express.
// Ports:
//   i_type  shift type from the instruction
//   i_rs8   low byte of Rs
//   i_rm    Rm value
//   i_cin   current carry flag
//   o_op    resolved operand/override bundle
// ---------------------------------------------------------------------------
module shift_amt_resolve
  import arm7_shift_pkg::*;
(
  input  logic [1:0]        i_type,
  input  logic [7:0]        i_rs8,
  input  logic [DATA_W-1:0] i_rm,
  input  logic              i_cin,
  output operand_t          o_op
);

  always_comb begin
    o_op      = '0;
    o_op.data = i_rm;
    o_op.typ  = SH_LSL;
    o_op.cin  = i_cin;
    // Rs[7:0] == 0 leaves the LSL #0 pass-through set up above
    if (i_rs8 != 8'd0) begin
      if (i_rs8 < 8'd32) begin
        o_op.typ = i_type;
        o_op.amt = i_rs8[4:0];
      end else begin
        case (shift_t'(i_type))
          SH_LSL: begin
            o_op.ovr_en   = 1'b1;
            o_op.ovr_data = '0;
            o_op.ovr_cout = (i_rs8 == 8'd32) & i_rm[0];
          end
          SH_LSR: begin
            o_op.ovr_en   = 1'b1;
            o_op.ovr_data = '0;
            o_op.ovr_cout = (i_rs8 == 8'd32) & i_rm[DATA_W-1];
          end
          SH_ASR: begin
            o_op.ovr_en   = 1'b1;
            o_op.ovr_data = {DATA_W{i_rm[DATA_W-1]}};
            o_op.ovr_cout = i_rm[DATA_W-1];
          end
          default: begin
            // ROR by a multiple of 32 returns Rm with C = Rm[31]; any other
            // amount is equivalent to ROR by Rs[4:0]
            if (i_rs8[4:0] == 5'd0) begin
              o_op.ovr_en   = 1'b1;
              o_op.ovr_data = i_rm;
              o_op.ovr_cout = i_rm[DATA_W-1];
            end else begin
              o_op.typ = SH_ROR;
              o_op.amt = i_rs8[4:0];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// ---------------------------------------------------------------------------
// shift_operand_stage
// Decodes the shifter operand of a data-processing instruction and presents
// a registered command (or a result override) to barrel_shifter.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  shift_operand_stage_if.slave: instruction handshake, Rs read port,
//        operand handshake and op_*/ovr_* outputs
// Build option:
//   SHIFT_OPSTAGE_REGSHIFT_EN  enables register-specified shifts (RS_RD state,
//   Rs read, latency 2). Without it, regshift instructions complete at
//   latency 1 as an override passing Rm and the current carry through.
// ---------------------------------------------------------------------------
module shift_operand_stage
  import arm7_shift_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  shift_operand_stage_if.slave bus
);

  state_t   r_state, w_state_nxt;
  operand_t r_op_p1, w_direct_p0;
  logic     r_out_valid_p1;
  logic     w_accept;
  logic     w_need_rs;
  logic     w_unused_bits;

  // Operands that need nothing beyond the instruction, Rm and C
  function automatic operand_t decode_direct(input logic [31:0]       instr,
                                             input logic [DATA_W-1:0] rm,
                                             input logic              cin);
    operand_t op;
    op     = '0;
    op.cin = cin;
    if (instr[INSTR_I_BIT]) begin
      op.data = {24'b0, instr[IMM8_HI:IMM8_LO]};
      // rot == 0 becomes LSL #0 so the shifter never sees ROR #0 (RRX)
      if (instr[ROT_HI:ROT_LO] != 4'd0) begin
        op.typ = SH_ROR;
        op.amt = {instr[ROT_HI:ROT_LO], 1'b0};
      end else begin
        op.typ = SH_LSL;
      end
    end else if (!instr[REGSHIFT_BIT]) begin
      op.data = rm;
      op.typ  = instr[TYPE_HI:TYPE_LO];
      op.amt  = instr[SHAMT_HI:SHAMT_LO];
    end else begin
      // Register shift without the Rs path: pass Rm and C straight through
      op.data     = rm;
      op.ovr_en   = 1'b1;
      op.ovr_data = rm;
      op.ovr_cout = cin;
    end
    return op;
  endfunction

  assign bus.in_ready = (r_state == ST_IDLE) || ((r_state == ST_OUT) && bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_direct_p0  = decode_direct(bus.instr, bus.rm_data, bus.cpsr_c);

`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
  logic [DATA_W-1:0] r_rm_p0;
  logic              r_cin_p0;
  logic [1:0]        r_type_p0;
  logic              r_rs_req_p0;
  logic [3:0]        r_rs_addr_p0;
  operand_t          w_resolved_p1;

  assign w_need_rs = !bus.instr[INSTR_I_BIT] && bus.instr[REGSHIFT_BIT];

  // Accept -> RS_RD: hold Rm/C/type and issue the Rs read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rm_p0      <= '0;
      r_cin_p0     <= 1'b0;
      r_type_p0    <= 2'b0;
      r_rs_req_p0  <= 1'b0;
      r_rs_addr_p0 <= 4'd0;
    end else begin
      r_rs_req_p0 <= w_accept && w_need_rs;
      if (w_accept && w_need_rs) begin
        r_rm_p0      <= bus.rm_data;
        r_cin_p0     <= bus.cpsr_c;
        r_type_p0    <= bus.instr[TYPE_HI:TYPE_LO];
        r_rs_addr_p0 <= bus.instr[RS_HI:RS_LO];
      end
    end
  end

  // rs_data returns on the edge that closes the rs_req cycle
  shift_amt_resolve u_resolve (
    .i_type (r_type_p0),
    .i_rs8  (bus.rs_data[7:0]),
    .i_rm   (r_rm_p0),
    .i_cin  (r_cin_p0),
    .o_op   (w_resolved_p1)
  );

  assign bus.rs_req  = r_rs_req_p0;
  assign bus.rs_addr = r_rs_addr_p0;
  assign w_unused_bits = ^{bus.instr[31:26], bus.instr[24:12], bus.rs_data[31:8]};
`else
  assign w_need_rs     = 1'b0;
  assign bus.rs_req    = 1'b0;
  assign bus.rs_addr   = 4'd0;
  assign w_unused_bits = ^{bus.instr[31:26], bus.instr[24:12], bus.rs_data};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_need_rs ? ST_RS_RD : ST_OUT;
      ST_RS_RD: w_state_nxt = ST_OUT;
      ST_OUT: begin
        // Handshake completes; an accept in the same cycle keeps the stream going
        if (bus.out_ready) begin
          if (w_accept) w_state_nxt = w_need_rs ? ST_RS_RD : ST_OUT;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register: op_* only change on a new operand, so a stall holds them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid_p1 <= 1'b0;
      r_op_p1        <= '0;
    end else begin
      r_out_valid_p1 <= (w_state_nxt == ST_OUT);
      if (w_accept && !w_need_rs) begin
        r_op_p1 <= w_direct_p0;
      end
`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
      else if (r_state == ST_RS_RD) begin
        r_op_p1 <= w_resolved_p1;
      end
`endif
    end
  end

  assign bus.out_valid = r_out_valid_p1;
  assign bus.op_data   = r_op_p1.data;
  assign bus.op_type   = r_op_p1.typ;
  assign bus.op_amt    = r_op_p1.amt;
  assign bus.op_cin    = r_op_p1.cin;
  assign bus.ovr_en    = r_op_p1.ovr_en;
  assign bus.ovr_data  = r_op_p1.ovr_data;
  assign bus.ovr_cout  = r_op_p1.ovr_cout;

endmodule

// File: tb/tb_shift_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_operand_stage
// Bench for shift_operand_stage. Honours SHIFT_OPSTAGE_REGSHIFT_EN the same
// way as the design.
// ---------------------------------------------------------------------------
module tb_shift_operand_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rm;
    logic        c;
    logic [31:0] rs;
    logic        ovr_en;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [4:0]  amt;
    logic        cin;
    logic [31:0] ovr_data;
    logic        ovr_cout;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] rf [16];

  shift_operand_stage_if bif ();

  shift_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file read port: data only meaningful while a read is pending
  assign bif.rs_data = bif.rs_req ? rf[bif.rs_addr] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] f_imm(input logic [7:0] imm, input logic [3:0] rot);
    return 32'hE200_0000 | {20'b0, rot, imm};
  endfunction

  function automatic logic [31:0] f_shi(input logic [4:0] sh, input logic [1:0] t);
    return 32'hE000_0000 | {20'b0, sh, t, 1'b0, 4'h2};
  endfunction

  function automatic logic [31:0] f_rsh(input logic [3:0] rs, input logic [1:0] t);
    return 32'hE000_0000 | {20'b0, rs, 1'b0, t, 1'b1, 4'h2};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rm, input logic c,
                              input logic [31:0] rs, input logic ovr_en, input logic [31:0] d,
                              input logic [1:0] t, input logic [4:0] a, input logic cin,
                              input logic [31:0] od, input logic oc, input int lat);
    vec_t v;
    v.instr = instr; v.rm = rm; v.c = c; v.rs = rs;
    v.ovr_en = ovr_en; v.data = d; v.typ = t; v.amt = a; v.cin = cin;
    v.ovr_data = od; v.ovr_cout = oc; v.lat = lat;
    return v;
  endfunction

  // Expected operand computed from the instruction-set rules
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    int   n;
    int   rot;
    r.ovr_en = 1'b0; r.data = 32'h0; r.typ = 2'd0; r.amt = 5'd0; r.cin = v.c;
    r.ovr_data = 32'h0; r.ovr_cout = 1'b0; r.lat = 1;
    if (v.instr[25]) begin
      rot    = int'(v.instr[11:8]);
      r.data = {24'h0, v.instr[7:0]};
      if (rot != 0) begin
        r.typ = 2'd3;
        r.amt = 5'(2 * rot);
      end
    end else if (!v.instr[4]) begin
      r.data = v.rm;
      r.typ  = v.instr[6:5];
      r.amt  = v.instr[11:7];
    end else begin
`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
      n      = int'(v.rs[7:0]);
      r.lat  = 2;
      r.data = v.rm;
      if (n >= 1 && n <= 31) begin
        r.typ = v.instr[6:5];
        r.amt = 5'(n);
      end else if (n >= 32) begin
        case (v.instr[6:5])
          2'd0: begin r.ovr_en = 1'b1; r.ovr_data = 32'h0; r.ovr_cout = (n == 32) ? v.rm[0] : 1'b0; end
          2'd1: begin r.ovr_en = 1'b1; r.ovr_data = 32'h0; r.ovr_cout = (n == 32) ? v.rm[31] : 1'b0; end
          2'd2: begin r.ovr_en = 1'b1; r.ovr_data = v.rm[31] ? 32'hFFFF_FFFF : 32'h0; r.ovr_cout = v.rm[31]; end
          default: begin
            if (n % 32 == 0) begin
              r.ovr_en = 1'b1; r.ovr_data = v.rm; r.ovr_cout = v.rm[31];
            end else begin
              r.typ = 2'd3; r.amt = 5'(n % 32);
            end
          end
        endcase
      end
`else
      n = 0;
      r.ovr_en = 1'b1; r.ovr_data = v.rm; r.ovr_cout = v.c;
`endif
    end
    return r;
  endfunction

  task automatic cmp_out(input vec_t v, input string tag);
    chk($sformatf("%s.ovr_en", tag), bif.ovr_en, v.ovr_en);
    if (v.ovr_en) begin
      chk($sformatf("%s.ovr_data", tag), bif.ovr_data, v.ovr_data);
      chk($sformatf("%s.ovr_cout", tag), bif.ovr_cout, v.ovr_cout);
    end else begin
      chk($sformatf("%s.op_data", tag), bif.op_data, v.data);
      chk($sformatf("%s.op_type", tag), bif.op_type, v.typ);
      chk($sformatf("%s.op_amt", tag), bif.op_amt, v.amt);
      chk($sformatf("%s.op_cin", tag), bif.op_cin, v.cin);
    end
  endtask

  // One transaction from IDLE with out_ready held high
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int lat;
    rf[v.instr[11:8]] = v.rs;
    bif.instr = v.instr; bif.rm_data = v.rm; bif.cpsr_c = v.c;
    bif.in_valid = 1'b1; bif.out_ready = 1'b1;
    n = 0;
    while (!bif.in_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!bif.in_ready) chk($sformatf("%s.in_ready_timeout", tag), 32'd0, 32'd1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0; bif.instr = $urandom; bif.rm_data = $urandom; bif.cpsr_c = 1'b0;
    chk($sformatf("%s.rs_req", tag), bif.rs_req, (v.lat == 2) ? 32'd1 : 32'd0);
    if (v.lat == 2) chk($sformatf("%s.rs_addr", tag), bif.rs_addr, v.instr[11:8]);
    lat = 1;
    while (!bif.out_valid && lat < 5) begin @(posedge clk); #1; lat++; end
    chk($sformatf("%s.latency", tag), lat, v.lat);
    chk($sformatf("%s.rs_req_in_out", tag), bif.rs_req, 32'd0);
    cmp_out(v, tag);
    @(posedge clk); #1;
    chk($sformatf("%s.out_valid_drop", tag), bif.out_valid, 32'd0);
  endtask

  vec_t tbl[$];
  vec_t va, vb, vc, vr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    bif.in_valid = 1'b0; bif.instr = 32'h0; bif.rm_data = 32'h0;
    bif.cpsr_c = 1'b0; bif.out_ready = 1'b0;
    rst = 1'b1;

    // Directed vectors
    tbl.push_back(mk(f_imm(8'hFF, 4'd1), 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_00FF, 2'd3, 5'd2, 1'b0, 32'h0, 1'b0, 1));
    tbl.push_back(mk(f_imm(8'h80, 4'd0), 32'h0, 1'b1, 32'h0, 1'b0, 32'h0000_0080, 2'd0, 5'd0, 1'b1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(f_imm(8'h3C, 4'd15), 32'h0, 1'b1, 32'h0, 1'b0, 32'h0000_003C, 2'd3, 5'd30, 1'b1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(f_shi(5'd5, 2'd1), 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h1234_5678, 2'd1, 5'd5, 1'b0, 32'h0, 1'b0, 1));
    tbl.push_back(mk(f_shi(5'd0, 2'd2), 32'h8000_0000, 1'b1, 32'h0, 1'b0, 32'h8000_0000, 2'd2, 5'd0, 1'b1, 32'h0, 1'b0, 1));
`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
    tbl.push_back(mk(f_rsh(4'd3, 2'd0), 32'h8000_0001, 1'b0, 32'd32, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b1, 2));
    tbl.push_back(mk(f_rsh(4'd3, 2'd0), 32'h8000_0001, 1'b0, 32'd33, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 2));
    tbl.push_back(mk(f_rsh(4'd5, 2'd3), 32'h8000_0000, 1'b0, 32'h40, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h8000_0000, 1'b1, 2));
    tbl.push_back(mk(f_rsh(4'd5, 2'd3), 32'h8000_0000, 1'b1, 32'h41, 1'b0, 32'h8000_0000, 2'd3, 5'd1, 1'b1, 32'h0, 1'b0, 2));
    tbl.push_back(mk(f_rsh(4'd7, 2'd1), 32'h8000_0000, 1'b0, 32'h20, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b1, 2));
    tbl.push_back(mk(f_rsh(4'd9, 2'd2), 32'h8000_0000, 1'b0, 32'hC8, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 2));
    tbl.push_back(mk(f_rsh(4'd1, 2'd1), 32'h0000_ABCD, 1'b1, 32'h100, 1'b0, 32'h0000_ABCD, 2'd0, 5'd0, 1'b1, 32'h0, 1'b0, 2));
    tbl.push_back(mk(f_rsh(4'd12, 2'd2), 32'hF000_0000, 1'b0, 32'h5, 1'b0, 32'hF000_0000, 2'd2, 5'd5, 1'b0, 32'h0, 1'b0, 2));
`else
    tbl.push_back(mk(f_rsh(4'd3, 2'd0), 32'h8000_0001, 1'b0, 32'd32, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h8000_0001, 1'b0, 1));
    tbl.push_back(mk(f_rsh(4'd5, 2'd3), 32'h0000_1234, 1'b1, 32'h41, 1'b1, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0000_1234, 1'b1, 1));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", bif.out_valid, 32'd0);
    chk("rst.in_ready", bif.in_ready, 32'd1);
    chk("rst.rs_req", bif.rs_req, 32'd0);
    chk("rst.rs_addr", bif.rs_addr, 32'd0);
    chk("rst.op_data", bif.op_data, 32'd0);
    chk("rst.op_type", bif.op_type, 32'd0);
    chk("rst.op_amt", bif.op_amt, 32'd0);
    chk("rst.op_cin", bif.op_cin, 32'd0);
    chk("rst.ovr_en", bif.ovr_en, 32'd0);
    chk("rst.ovr_data", bif.ovr_data, 32'd0);
    chk("rst.ovr_cout", bif.ovr_cout, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure and same-cycle re-accept
    va = ref_model(mk(f_imm(8'h11, 4'd4), 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1));
    vb = ref_model(mk(f_shi(5'd3, 2'd0), 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1));
    vc = ref_model(mk(f_imm(8'h22, 4'd0), 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1));
    bif.instr = va.instr; bif.rm_data = va.rm; bif.cpsr_c = va.c;
    bif.in_valid = 1'b1; bif.out_ready = 1'b0;
    @(posedge clk); #1;
    bif.instr = vb.instr; bif.rm_data = vb.rm; bif.cpsr_c = vb.c;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d.out_valid", k), bif.out_valid, 32'd1);
      chk($sformatf("stall%0d.in_ready", k), bif.in_ready, 32'd0);
      cmp_out(va, $sformatf("stall%0d", k));
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_b.out_valid", bif.out_valid, 32'd1);
    cmp_out(vb, "b2b_b");
    bif.instr = vc.instr; bif.rm_data = vc.rm; bif.cpsr_c = vc.c;
    @(posedge clk); #1;
    chk("b2b_c.out_valid", bif.out_valid, 32'd1);
    cmp_out(vc, "b2b_c");
    bif.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.drain", bif.out_valid, 32'd0);

    // Reset while an operand is in flight
`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
    bif.instr = f_rsh(4'd3, 2'd0);
`else
    bif.instr = f_imm(8'h55, 4'd2);
`endif
    rf[3] = 32'h20; bif.rm_data = 32'h8000_0001; bif.cpsr_c = 1'b1;
    bif.in_valid = 1'b1; bif.out_ready = 1'b0;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
`ifdef SHIFT_OPSTAGE_REGSHIFT_EN
    chk("midrst.rs_req_before", bif.rs_req, 32'd1);
`else
    chk("midrst.out_valid_before", bif.out_valid, 32'd1);
`endif
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", bif.out_valid, 32'd0);
    chk("midrst.rs_req", bif.rs_req, 32'd0);
    chk("midrst.op_data", bif.op_data, 32'd0);
    chk("midrst.ovr_en", bif.ovr_en, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.idle_in_ready", bif.in_ready, 32'd1);
    chk("midrst.idle_out_valid", bif.out_valid, 32'd0);
    run_vec(tbl[0], "postrst");

    // Randomized instructions against the reference model
    for (int i = 0; i < 200; i++) begin
      vr = mk($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1);
      vr.instr[25] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: vr.rs[7:0] = 8'd0;
        1: vr.rs[7:0] = 8'd32;
        2: vr.rs[7:0] = 8'($urandom_range(1, 31));
        3: vr.rs[7:0] = 8'($urandom_range(32, 255));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) vr.rm = {1'b1, 30'($urandom), 1'b1};
      vr = ref_model(vr);
      run_vec(vr, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_operand_stage.md
SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  instruction handshake; transfer when both are high on a clk edge.
REQ-005 instr  input  32  data-processing instruction; I=[25], rot=[11:8], imm8=[7:0], shamt=[11:7], type=[6:5], regshift=[4], Rs=[11:8].
REQ-006 rm_data  input  32  Rm value, valid with in_valid.
REQ-007 cpsr_c  input  1  current carry flag, valid with in_valid.
REQ-008 rs_req / rs_addr  output  1 / 4  single-cycle Rs register-file read request and address.
REQ-009 rs_data  input  32  Rs value, valid exactly one cycle after rs_req.
REQ-010 out_valid / out_ready  output / input  1 / 1  operand handshake toward barrel_shifter.
REQ-011 op_data, op_type, op_amt, op_cin  output  32, 2, 5, 1  barrel_shifter data_in, shift_type, shift_amt, carry_in.
REQ-012 ovr_en, ovr_data, ovr_cout  output  1, 32, 1  when ovr_en=1, the consumer SHALL use ovr_data/ovr_cout in place of shifter results.

Function
REQ-013 States SHALL be IDLE, RS_RD and OUT; in_ready=1 in IDLE, and in OUT only when out_ready=1.
REQ-014 On accept with I=1 or regshift=0: go to OUT next cycle, latency 1.
REQ-015 On accept with I=0 and regshift=1: go to RS_RD, pulse rs_req for that cycle with rs_addr=instr[11:8], then go to OUT; latency 2.
REQ-016 rm_data, cpsr_c and instr SHALL be captured at accept; rs_data SHALL be captured in RS_RD.
REQ-017 Immediate, rot!=0: op_data={24'b0,imm8}, op_type=ROR, op_amt=2*rot, op_cin=cpsr_c, ovr_en=0.
REQ-018 Immediate, rot=0: op_type=LSL, op_amt=0, op_data=imm8, op_cin=cpsr_c; SHALL never emit ROR #0.
REQ-019 Immediate-amount shift: op_data=Rm, op_type=type, op_amt=shamt, op_cin=cpsr_c passed unchanged, ovr_en=0.
REQ-020 Register shift with Rs[7:0]=0: op_type=LSL, op_amt=0, op_data=Rm, op_cin=cpsr_c.
REQ-021 Register shift with 1<=Rs[7:0]<=31: op_type=type, op_amt=Rs[4:0], ovr_en=0.
REQ-022 Register shift with Rs[7:0]>=32, ovr_en=1:
  - LSL: ovr_data=0; ovr_cout=Rm[0] if Rs[7:0]=32, else 0.
  - LSR: ovr_data=0; ovr_cout=Rm[31] if Rs[7:0]=32, else 0.
  - ASR: ovr_data={32{Rm[31]}}; ovr_cout=Rm[31].
  - ROR with Rs[4:0]=0: ovr_data=Rm, ovr_cout=Rm[31].
  - ROR with Rs[4:0]!=0: op_type=ROR, op_amt=Rs[4:0], ovr_en=0.
REQ-023 While out_valid=1 and out_ready=0, all op_*/ovr_* outputs SHALL be held stable.
REQ-024 In OUT, out_ready=1 together with in_valid=1 SHALL accept the next instruction in the same cycle, giving back-to-back throughput of 1 per cycle for immediate forms.
REQ-025 out_valid SHALL be 1 only in OUT; all outputs SHALL be registered.

Reset
REQ-026 rst SHALL force IDLE with out_valid=0, rs_req=0, rs_addr=0, op_*=0, ovr_*=0.
REQ-027 Assertion of rst in RS_RD or OUT SHALL discard the in-flight operand; after release, the first accept SHALL behave as if from power-up.

Configuration
REQ-028 With SHIFT_OPSTAGE_REGSHIFT_EN defined, REQ-015/020/021/022 SHALL apply.
REQ-029 Without SHIFT_OPSTAGE_REGSHIFT_EN: RS_RD SHALL be absent and rs_req tied 0; a regshift=1 instruction SHALL take latency 1 with ovr_en=1, ovr_data=Rm, ovr_cout=cpsr_c.

Structure
REQ-030 Package arm7_shift_pkg SHALL hold the shift-type constants (LSL/LSR/ASR/ROR = 0..3), state encoding and instruction field positions, shared with barrel_shifter.
REQ-031 Sub-module shift_amt_resolve (combinational) SHALL implement REQ-020..022 from type, Rs[7:0] and Rm.

Verification
REQ-032 Immediate: imm8=0xFF, rot=1, C=0 -> 1 cycle later op_data=0x000000FF, op_type=ROR, op_amt=2, ovr_en=0.
REQ-033 Immediate: imm8=0x80, rot=0, C=1 -> op_type=LSL, op_amt=0, op_cin=1.
REQ-034 Register LSL, Rm=0x80000001: Rs=32 -> rs_req pulse then out_valid after 2 cycles, ovr_en=1, ovr_data=0, ovr_cout=1; Rs=33 -> ovr_cout=0.
REQ-035 Register ROR, Rm=0x80000000, Rs=0x40 -> ovr_data=0x80000000, ovr_cout=1; Rs=0x41 -> op_type=ROR, op_amt=1.
REQ-036 out_ready=0 for 3 cycles -> outputs stable and in_ready=0; out_ready=1 with in_valid=1 -> new accept in same cycle, next out_valid 1 cycle later.
REQ-037 rst pulsed in RS_RD -> out_valid=0 and IDLE next cycle; the subsequent immediate instruction produces correct output at latency 1.
